ad_ip_jesd204_tpl_adc_pn_sweep: RTL and testbench

//  Sequencer for the TPL ADC PN checkers; sits between regmap and core on link_clk.

---
 rtl/ad_ip_jesd204_tpl_adc_pn_sweep.sv | 148 ++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_pn_sweep.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_pn_sweep.sv
// PN sequence sweep for the TPL ADC checkers: steps every channel through a list of
// PN codes, lets each settle, then records a per-entry, per-channel pass/fail bitmap.
//
// state  | meaning
// IDLE   | software PN select forwarded to the core
// APPLY  | entry[seq_index] driven on all channels
// SETTLE | waiting for the PN checkers to lock
// CHECK  | accumulating pn_err/pn_oos over link_valid cycles
// NEXT   | store result, advance to next entry or finish
// DONE   | completion pulse, hand PN select back to software
module ad_ip_jesd204_tpl_adc_pn_sweep #(
    parameter int NUM_CHANNELS  = 1,
    parameter int NUM_SEQ       = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int CHECK_CYCLES  = 256,
    localparam int IDX_W        = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_CHANNELS*4-1:0]       cfg_seq_sel,
    input  logic [NUM_SEQ*4-1:0]            seq_list,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            link_valid,
    input  logic [NUM_CHANNELS-1:0]         pn_err,
    input  logic [NUM_CHANNELS-1:0]         pn_oos,
    output logic [NUM_CHANNELS*4-1:0]       pn_seq_sel,
    output logic                            busy,
    output logic                            done,
    output logic                            aborted,
    output logic [IDX_W-1:0]                seq_index,
    output logic [NUM_SEQ*NUM_CHANNELS-1:0] result_pass
);

    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic                       abort_go;
    logic [IDX_W-1:0]           idx_nxt;
    logic [NUM_SEQ*4-1:0]       seq_src;
    logic [NUM_SEQ*4-1:0]       seq_latched;
    logic [3:0]                 entry_nxt;
    logic [CNT_W-1:0]           cnt;
    logic [NUM_CHANNELS-1:0]    fail_acc;
    logic                       last_idx;
    logic                       cnt_tc;

    assign busy     = (state != ST_IDLE);
    assign last_idx = (seq_index == IDX_W'(NUM_SEQ - 1));
    assign cnt_tc   = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        abort_go  = 1'b0;
        case (state)
            ST_IDLE:   if (start && !abort) state_nxt = ST_APPLY;
            ST_APPLY:  state_nxt = ST_SETTLE;
            ST_SETTLE: if (cnt_tc) state_nxt = ST_CHECK;
            ST_CHECK:  if (link_valid && cnt_tc) state_nxt = ST_NEXT;
            ST_NEXT:   state_nxt = last_idx ? ST_DONE : ST_APPLY;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        // DONE always completes, so a late abort there is ignored
        if (abort && (state != ST_IDLE) && (state != ST_DONE)) begin
            state_nxt = ST_IDLE;
            abort_go  = 1'b1;
        end
    end

    // Entry loaded on the edge into APPLY: fresh list on start, latched list afterwards
    always_comb begin
        idx_nxt   = (state == ST_IDLE) ? '0 : seq_index + IDX_W'(1);
        seq_src   = (state == ST_IDLE) ? seq_list : seq_latched;
        entry_nxt = '0;
        for (int i = 0; i < NUM_SEQ; i++) begin
            if (idx_nxt == IDX_W'(i)) entry_nxt = seq_src[i*4 +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pn_seq_sel  <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            seq_index   <= '0;
            result_pass <= '0;
            seq_latched <= '0;
            cnt         <= '0;
            fail_acc    <= '0;
        end else begin
            done    <= (state_nxt == ST_DONE);
            aborted <= abort_go;

            if (state_nxt == ST_APPLY) begin
                pn_seq_sel <= {NUM_CHANNELS{entry_nxt}};
                seq_index  <= idx_nxt;
            end else if (state_nxt == ST_IDLE) begin
                pn_seq_sel <= cfg_seq_sel;
            end

            if (state == ST_IDLE && state_nxt == ST_APPLY) begin
                seq_latched <= seq_list;
                result_pass <= '0;
            end

            if (state == ST_NEXT && !abort_go) begin
                for (int i = 0; i < NUM_SEQ; i++) begin
                    if (seq_index == IDX_W'(i)) result_pass[i*NUM_CHANNELS +: NUM_CHANNELS] <= ~fail_acc;
                end
            end

            if (state == ST_APPLY) begin
                cnt <= CNT_W'(SETTLE_CYCLES);
            end else if (state == ST_SETTLE) begin
                if (cnt_tc) begin
                    cnt      <= CNT_W'(CHECK_CYCLES);
                    fail_acc <= '0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end else if (state == ST_CHECK && link_valid) begin
                fail_acc <= fail_acc | pn_err | pn_oos;
                cnt      <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_sweep.sv
// Randomized bench for the PN sweep sequencer; expected timeline and results are
// derived per sweep from the stimulus arrays with plain arithmetic.
module tb_ad_ip_jesd204_tpl_adc_pn_sweep;

    localparam int NC   = 2;
    localparam int NS   = 2;
    localparam int SC   = 4;
    localparam int CC   = 8;
    localparam int MAXC = 256;
    localparam int IW   = (NS > 1) ? $clog2(NS) : 1;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NC*4-1:0]   cfg_seq_sel = '0;
    logic [NS*4-1:0]   seq_list = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              link_valid = 1'b1;
    logic [NC-1:0]     pn_err = '0;
    logic [NC-1:0]     pn_oos = '0;
    logic [NC*4-1:0]   pn_seq_sel;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [IW-1:0]     seq_index;
    logic [NS*NC-1:0]  result_pass;

    int errors = 0;
    int checks = 0;

    ad_ip_jesd204_tpl_adc_pn_sweep #(
        .NUM_CHANNELS (NC),
        .NUM_SEQ      (NS),
        .SETTLE_CYCLES(SC),
        .CHECK_CYCLES (CC)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_seq_sel(cfg_seq_sel),
        .seq_list   (seq_list),
        .start      (start),
        .abort      (abort),
        .link_valid (link_valid),
        .pn_err     (pn_err),
        .pn_oos     (pn_oos),
        .pn_seq_sel (pn_seq_sel),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .seq_index  (seq_index),
        .result_pass(result_pass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NC*4-1:0] rep(input logic [3:0] s);
        logic [NC*4-1:0] r;
        for (int c = 0; c < NC; c++) r[c*4 +: 4] = s;
        return r;
    endfunction

    // mode 0: plain sweep, 1: abort in entry-1 settle, 2: abort during DONE, 3: reset mid-CHECK
    task automatic sweep(input int mode, input bit lv_rand, input bit noisy);
        bit              lv[MAXC];
        logic [NC-1:0]   er[MAXC];
        logic [NC-1:0]   oo[MAXC];
        int              apply_c[NS];
        int              next_c[NS];
        logic [NC-1:0]   fail[NS];
        logic [3:0]      sq[NS];
        logic [NC*4-1:0] cfg_v;
        logic [NS*NC-1:0] res_e;
        logic [NC*4-1:0] pn_e;
        int              idx_e;
        int              pos, k, n, done_c, ev_at, stop;

        for (int j = 0; j < MAXC; j++) begin
            lv[j] = (lv_rand && j < 150) ? ($urandom_range(0, 2) != 0) : 1'b1;
            er[j] = (noisy && $urandom_range(0, 19) == 0) ? NC'($urandom) : '0;
            oo[j] = (noisy && $urandom_range(0, 19) == 0) ? NC'($urandom) : '0;
        end
        for (int i = 0; i < NS; i++) sq[i] = 4'($urandom);
        cfg_v = (NC*4)'($urandom);

        pos = 1;
        for (int i = 0; i < NS; i++) begin
            apply_c[i] = pos;
            k = pos + 1 + SC;
            n = 0;
            fail[i] = '0;
            while (n < CC && k < MAXC - 2) begin
                if (lv[k]) begin
                    fail[i] = fail[i] | er[k] | oo[k];
                    n++;
                end
                k++;
            end
            next_c[i] = k;
            pos = k + 1;
        end
        done_c = pos;

        case (mode)
            1:       ev_at = apply_c[1] + 1 + $urandom_range(0, SC - 1);
            2:       ev_at = done_c;
            3:       ev_at = apply_c[0] + SC + 1 + $urandom_range(0, next_c[0] - (apply_c[0] + SC + 1) - 1);
            default: ev_at = 0;
        endcase
        stop = (mode == 1 || mode == 3) ? ev_at + 1 : done_c + 1;

        cfg_seq_sel = cfg_v;
        for (int i = 0; i < NS; i++) seq_list[i*4 +: 4] = sq[i];
        start = 1'b1;
        abort = 1'b0;
        tick;

        for (int j = 1; j <= stop; j++) begin
            res_e = '0;
            for (int i = 0; i < NS; i++) if (next_c[i] < j) res_e[i*NC +: NC] = ~fail[i];

            if (mode == 3 && j == stop) begin
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_done", 32'(done), 32'(0));
                chk("rst_aborted", 32'(aborted), 32'(0));
                chk("rst_pn", 32'(pn_seq_sel), 32'(0));
                chk("rst_idx", 32'(seq_index), 32'(0));
                chk("rst_result", 32'(result_pass), 32'(0));
            end else if (mode == 1 && j == stop) begin
                chk("ab_busy", 32'(busy), 32'(0));
                chk("ab_pulse", 32'(aborted), 32'(1));
                chk("ab_done", 32'(done), 32'(0));
                chk("ab_result", 32'(result_pass), 32'(res_e));
                chk("ab_pn", 32'(pn_seq_sel), 32'(cfg_v));
            end else begin
                idx_e = NS - 1;
                pn_e  = cfg_v;
                if (j <= done_c) pn_e = rep(sq[NS-1]);
                for (int i = 0; i < NS; i++) begin
                    if (j >= apply_c[i] && j <= next_c[i]) begin
                        idx_e = i;
                        pn_e  = rep(sq[i]);
                    end
                end
                chk("busy", 32'(busy), 32'(j <= done_c));
                chk("done", 32'(done), 32'(j == done_c));
                chk("aborted", 32'(aborted), 32'(0));
                chk("result", 32'(result_pass), 32'(res_e));
                chk("pn_sel", 32'(pn_seq_sel), 32'(pn_e));
                if (j <= done_c) chk("seq_index", 32'(seq_index), 32'(idx_e));
            end

            link_valid = lv[j];
            pn_err     = er[j];
            pn_oos     = oo[j];
            start      = (j < stop && j <= done_c) ? ($urandom_range(0, 3) == 0) : 1'b0;
            abort      = ((mode == 1 || mode == 2) && j == ev_at);
            resetn     = !(mode == 3 && j == ev_at);
            tick;
        end

        if (mode == 1) chk("ab_clear", 32'(aborted), 32'(0));
        start      = 1'b0;
        abort      = 1'b0;
        resetn     = 1'b1;
        link_valid = 1'b1;
        pn_err     = '0;
        pn_oos     = '0;
    endtask

    initial begin
        logic [NC*4-1:0] c;

        resetn = 1'b0;
        tick;
        tick;
        chk("init_busy", 32'(busy), 32'(0));
        chk("init_done", 32'(done), 32'(0));
        chk("init_aborted", 32'(aborted), 32'(0));
        chk("init_pn", 32'(pn_seq_sel), 32'(0));
        chk("init_idx", 32'(seq_index), 32'(0));
        chk("init_result", 32'(result_pass), 32'(0));
        resetn = 1'b1;
        tick;

        for (int i = 0; i < 4; i++) begin
            c = (NC*4)'($urandom);
            cfg_seq_sel = c;
            tick;
            chk("idle_fwd", 32'(pn_seq_sel), 32'(c));
        end

        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("clash_busy", 32'(busy), 32'(0));
        chk("clash_aborted", 32'(aborted), 32'(0));
        tick;
        chk("clash_idle", 32'(busy), 32'(0));

        sweep(0, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) sweep(0, 1'b1, 1'b1);
        sweep(1, 1'b0, 1'b0);
        sweep(1, 1'b1, 1'b1);
        sweep(2, 1'b1, 1'b1);
        sweep(3, 1'b1, 1'b1);
        sweep(0, 1'b0, 1'b0);
        sweep(0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
